// File: rtl/alarm_ringer_pkg.sv
// Shared types and constants for the alarm ringer.
// State encoding, BCD zero and parameter defaults.
package alarm_ringer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    localparam logic [7:0] BCD_ZERO = 8'h00;

    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 300;
    localparam int MAX_SNOOZE_DEF  = 3;

    // Bits needed to count up to the longer of the two periods.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Time/alarm inputs and buzzer status outputs of the ringer.
// master drives time and keys, slave is the ringer.
interface alarm_ringer_if;
    logic [7:0] Hour;
    logic [7:0] Minute;
    logic [7:0] Second;
    logic [7:0] AHour;
    logic [7:0] AMinute;
    logic       alarm_en;
    logic       snooze_key;
    logic       stop_key;
    logic       ringing;
    logic       beep;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    modport master (
        output Hour, Minute, Second, AHour, AMinute,
        output alarm_en, snooze_key, stop_key,
        input  ringing, beep, snoozing, snooze_cnt
    );

    modport slave (
        input  Hour, Minute, Second, AHour, AMinute,
        input  alarm_en, snooze_key, stop_key,
        output ringing, beep, snoozing, snooze_cnt
    );
endinterface

// File: rtl/alarm_ringer_key.sv
// Rising-edge detector for a debounced key level.
// A held key produces a single one-cycle pulse.
module key_pulse (
    input  logic clk_1,
    input  logic ncr,
    input  logic key_in,
    output logic pulse
);

    logic key_q;
    logic key_d;

    // Next history value is simply the current level.
    always_comb begin
        key_d = key_in;
    end

    // Remember last cycle's level; cleared by reset.
    always_ff @(posedge clk_1) begin
        if (ncr) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key_d;
        end
    end

    assign pulse = key_in & ~key_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm comparator and ring/snooze/stop state machine.
// One clk_1 cycle is one second of wall time.
module alarm_ringer
    import alarm_ringer_pkg::*;
#(
    parameter int RING_SECS   = RING_SECS_DEF,
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
    input  logic           clk_1,
    input  logic           ncr,
    alarm_ringer_if.slave  bus
);

    localparam int TW = timer_width(RING_SECS, SNOOZE_SECS);

    localparam logic [TW-1:0] RING_LAST   = TW'(RING_SECS - 1);
    localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SECS - 1);
    localparam logic [TW-1:0] TIMER_MAX   = {TW{1'b1}};
    localparam logic [1:0]    CNT_MAX     = 2'(MAX_SNOOZE);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          match_q, match_d;

    logic          match;
    logic          trigger;
    logic          snz;
    logic          stp;
    logic [TW-1:0] timer_inc;

    key_pulse u_snz (
        .clk_1  (clk_1),
        .ncr    (ncr),
        .key_in (bus.snooze_key),
        .pulse  (snz)
    );

    key_pulse u_stp (
        .clk_1  (clk_1),
        .ncr    (ncr),
        .key_in (bus.stop_key),
        .pulse  (stp)
    );

    // Alarm match: straight BCD compare, first second of the minute.
    always_comb begin
        match   = bus.alarm_en
                & (bus.Hour == bus.AHour)
                & (bus.Minute == bus.AMinute)
                & (bus.Second == BCD_ZERO);
        match_d = match;
        trigger = match & ~match_q;
    end

    // Saturating second counter increment.
    always_comb begin
        timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    end

    // Next-state logic; disable and stop outrank snooze and timeouts.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = RING;
                    timer_d = '0;
                    phase_d = 1'b0;
                    cnt_d   = 2'd0;
                end
            end
            RING: begin
                if (!bus.alarm_en || stp) begin
                    state_d = IDLE;
                    timer_d = '0;
                    phase_d = 1'b0;
                    cnt_d   = 2'd0;
                end else if (snz || timer_q == RING_LAST) begin
                    timer_d = '0;
                    phase_d = 1'b0;
                    if (cnt_q < CNT_MAX) begin
                        state_d = SNOOZE;
                        cnt_d   = cnt_q + 2'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end
                end else begin
                    timer_d = timer_inc;
                    phase_d = ~phase_q;
                end
            end
            SNOOZE: begin
                if (!bus.alarm_en || stp) begin
                    state_d = IDLE;
                    timer_d = '0;
                    phase_d = 1'b0;
                    cnt_d   = 2'd0;
                end else if (timer_q == SNOOZE_LAST) begin
                    state_d = RING;
                    timer_d = '0;
                    phase_d = 1'b0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                phase_d = 1'b0;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // FSM, timer, phase and match history registers.
    always_ff @(posedge clk_1) begin
        if (ncr) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= 2'd0;
            phase_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            match_q <= match_d;
        end
    end

    assign bus.ringing    = (state_q == RING);
    assign bus.beep       = (state_q == RING) & ~phase_q;
    assign bus.snoozing   = (state_q == SNOOZE);
    assign bus.snooze_cnt = cnt_q;

endmodule
